// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock,
// start/done handshake, divide-by-zero reported through dz.
module seq_restoring_divider #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         dz
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   r_q, r_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   d_q, d_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           dz_q, dz_d;

  logic           accept;
  logic           div_zero;
  logic           last_step;
  logic [W:0]     shifted;
  logic [W:0]     trial;

  // start is honoured in IDLE and DONE only; while iterating it is ignored
  assign accept    = start && (state_q != S_RUN);
  assign div_zero  = (divisor == '0);
  assign last_step = (state_q == S_RUN) && (cnt_q == CW'(1));

  // shifted keeps the bit pushed out of R, so the trial is exact at W+1 bits
  assign shifted = {r_q, q_q[W-1]};
  assign trial   = shifted - {1'b0, d_q};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = div_zero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (last_step) state_d = S_DONE;
      end
      S_DONE: begin
        if (start) state_d = div_zero ? S_DONE : S_RUN;
        else       state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next-state
  always_comb begin
    cnt_d = cnt_q;
    r_d   = r_q;
    q_d   = q_q;
    d_d   = d_q;
    quo_d = quo_q;
    rem_d = rem_q;
    dz_d  = dz_q;
    if (accept) begin
      q_d   = dividend;
      d_d   = divisor;
      r_d   = '0;
      dz_d  = 1'b0;
      cnt_d = CW'(W);
      if (div_zero) begin
        quo_d = '1;
        rem_d = dividend;
        dz_d  = 1'b1;
        cnt_d = '0;
      end
    end else if (state_q == S_RUN) begin
      // negative trial means restore: keep the shifted remainder, quotient bit 0
      r_d   = trial[W] ? shifted[W-1:0] : trial[W-1:0];
      q_d   = {q_q[W-2:0], ~trial[W]};
      cnt_d = cnt_q - CW'(1);
      if (last_step) begin
        quo_d = q_d;
        rem_d = r_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      r_q   <= '0;
      q_q   <= '0;
      d_q   <= '0;
      quo_q <= '0;
      rem_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      r_q   <= r_d;
      q_q   <= q_d;
      d_q   <= d_d;
      quo_q <= quo_d;
      rem_q <= rem_d;
      dz_q  <= dz_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign dz        = dz_q;

endmodule
